// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Fetch-stage opcodes, widths and FSM encoding.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_HALT = 7'b1010101;
  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush beats load beats drain.
module if_id_reg #(
  parameter int AW = 5,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic          drain,
  input  logic [IW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  output logic          valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, run/halt FSM and IF/ID register.
// Redirect overrides stall and halt.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [6:0] HALT_OPCODE = cpu_pkg::OPC_HALT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted
);

  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic accept, is_halt, fetch, drain;

  assign accept = !if_valid || id_ready;
  assign is_halt = instruction[6:0] == HALT_OPCODE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FS_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      redirect_valid:    state_nxt = FS_RUN;
      fetch && is_halt:  state_nxt = FS_HALT;
      default:           state_nxt = state;
    endcase
  end

  always_comb begin
    fetch  = (state == FS_RUN) && !redirect_valid && accept;
    drain  = (state == FS_HALT) && id_ready;
    pc_nxt = pc;
    unique case (1'b1)
      redirect_valid:    pc_nxt = redirect_addr;
      fetch && !is_halt: pc_nxt = pc + ADDR_W'(1);
      default:           pc_nxt = pc;
    endcase
  end

  assign prog_addr = pc;
  assign halted = (state == FS_HALT);

  if_id_reg #(
    .AW(ADDR_W),
    .IW(INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (reset),
    .load    (fetch),
    .flush   (redirect_valid),
    .drain   (drain),
    .d_instr (instruction),
    .d_pc    (pc),
    .valid   (if_valid),
    .instr   (if_instr),
    .pc      (if_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus
// randomized traffic against a reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  prog_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        halted;

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ifpc;
  bit          m_halted;

  assign instruction = mem[prog_addr];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .prog_addr      (prog_addr),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_valid = 0;
    m_instr = 32'h0;
    m_ifpc = 0;
    m_halted = 0;
  endtask

  task automatic model_clock(input bit rdy, input bit rv,
                             input int ra);
    logic [31:0] w;
    if (rv) begin
      m_pc = ra;
      m_valid = 0;
      m_instr = 32'h0;
      m_halted = 0;
    end else if (m_halted) begin
      if (rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      w = mem[m_pc];
      m_instr = w;
      m_ifpc = m_pc;
      m_valid = 1;
      if (w[6:0] == 7'b1010101) m_halted = 1;
      else m_pc = (m_pc + 1) % 32;
    end
  endtask

  task automatic cmp_all();
    check("prog_addr", 64'(prog_addr), 64'(m_pc));
    check("if_valid", 64'(if_valid), 64'(m_valid));
    check("if_instr", 64'(if_instr), 64'(m_instr));
    check("if_pc", 64'(if_pc), 64'(m_ifpc));
    check("halted", 64'(halted), 64'(m_halted));
  endtask

  task automatic step(input bit rdy, input bit rv, input int ra);
    id_ready = rdy;
    redirect_valid = rv;
    redirect_addr = 5'(ra);
    @(posedge clk);
    model_clock(rdy, rv, ra);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 5'd0;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i);
    mem[8] = 32'h55;
  endtask

  initial begin
    reset = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 5'd0;
    load_prog();
    #2;
    do_reset();

    // straight-line run into HALT at 8
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      check("run_pc", 64'(if_pc), 64'(i));
      check("run_instr", 64'(if_instr), 64'(i));
    end
    step(1, 0, 0);
    check("halt_instr", 64'(if_instr), 64'h55);
    check("halt_flag", 64'(halted), 64'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    check("halt_addr", 64'(prog_addr), 64'd8);
    check("halt_drain", 64'(if_valid), 64'd0);

    // redirect out of HALT
    step(1, 1, 0);
    check("rd_halted", 64'(halted), 64'd0);
    step(1, 0, 0);
    check("rd_first", 64'(if_pc), 64'd0);

    // stall at if_pc=3
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("stall_addr", 64'(prog_addr), 64'd4);
      check("stall_pc", 64'(if_pc), 64'd3);
    end
    step(1, 0, 0);
    check("post_stall", 64'(if_pc), 64'd4);
    step(1, 0, 0);

    // redirect while stalled at if_pc=5
    step(0, 0, 0);
    step(0, 1, 2);
    check("flush_v", 64'(if_valid), 64'd0);
    step(1, 0, 0);
    check("rd2_pc", 64'(if_pc), 64'd2);
    check("rd2_in", 64'(if_instr), 64'd2);
    step(1, 0, 0);
    check("rd2_next", 64'(if_pc), 64'd3);

    // wrap past 31
    step(1, 1, 30);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("wrap_pc", 64'(if_pc), 64'((30 + i) % 32));
    end

    // async reset between edges
    step(1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_v", 64'(if_valid), 64'd0);
    check("async_h", 64'(halted), 64'd0);
    check("async_a", 64'(prog_addr), 64'd0);
    do_reset();
    step(1, 0, 0);
    check("after_rst", 64'(if_pc), 64'd0);

    // randomized traffic
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      if (mem[i][6:0] == 7'b1010101) mem[i][0] = 1'b0;
      if ($urandom_range(7) == 0) mem[i][6:0] = 7'b1010101;
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        @(negedge clk);
        do_reset();
      end else begin
        step($urandom_range(3) != 0,
             $urandom_range(19) == 0,
             int'($urandom_range(31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of PROGRAM_MEMORY. Owns the program counter, drives prog_addr and captures the returned instruction into an IF/ID pipeline register with a valid/ready handshake to decode. Supports stall from decode, redirect (branch/jump) with flush, and halt on the HALT opcode.

Parameters:
ADDR_W, 5, program-memory address width (32 words)
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 7'b1010101, opcode (instr[6:0]) that stops fetching

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
prog_addr  output  ADDR_W  address to PROGRAM_MEMORY; equals PC register
instruction  input  INSTR_W  PROGRAM_MEMORY read data; combinational from prog_addr, valid in the same cycle
redirect_valid  input  1  load redirect_addr into PC and flush IF/ID
redirect_addr  input  ADDR_W  redirect target
id_ready  input  1  decode accepts if_instr this cycle
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  INSTR_W  registered instruction
if_pc  output  ADDR_W  address the registered instruction came from
halted  output  1  high while in HALT state

Behaviour:
- Reset (reset==0, async): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, state=RUN.
- prog_addr = pc (direct from register, no logic).
- accept = !if_valid || id_ready (IF/ID slot free or being drained).
- State RUN, redirect_valid==0, accept==1: if_instr<=instruction, if_pc<=pc, if_valid<=1, pc<=pc+1 modulo 2**ADDR_W (31 wraps to 0).
- Same, and instruction[6:0]==HALT_OPCODE: HALT instruction is still registered (if_valid<=1) so decode sees it; pc is NOT incremented; state<=HALT.
- RUN, accept==0 (stall): pc, if_instr, if_pc, if_valid all hold.
- State HALT: no fetch; pc holds; halted=1; if_valid clears to 0 when id_ready==1, otherwise holds.
- redirect_valid==1 (any state, highest priority, overrides stall and halt): pc<=redirect_addr, if_valid<=0, if_instr<=0, state<=RUN. The instruction present that cycle is discarded. First fetch from redirect_addr is registered the following cycle.
- Latency: instruction at address A appears on if_instr/if_valid one cycle after prog_addr==A. Sustained throughput one instruction per cycle with id_ready held high.
- All-zero instruction is a NOP and is forwarded like any other word.
- halted is a registered output equal to (state==HALT).
- Reset asserted mid-operation immediately returns all outputs to reset values; the first fetch after release is from RESET_PC on the first rising edge.

Decomposition:
- Shared package cpu_pkg: ADDR_W/INSTR_W constants, OPC_HALT=7'b1010101, NOP=32'h0, fetch_state_t enum {FS_RUN, FS_HALT}.
- Sub-module if_id_reg (valid/ready pipeline register with flush input) is natural; PC and FSM stay in the top.

Test Plan:
- Reset then run, memory word[i]=i for i<8, word[8]=32'h55, id_ready=1 -> if_pc 0..7 on consecutive cycles with if_instr==if_pc, then if_instr=32'h55 at if_pc=8, halted=1 next cycle, prog_addr stays 8.
- Stall: id_ready=0 for 3 cycles while if_pc=3 -> if_instr/if_pc/prog_addr (4) frozen, no instruction lost or duplicated after release.
- Redirect while stalled at if_pc=5, redirect_addr=2 -> if_valid=0 next cycle, then if_pc=2 with if_instr=2, continuing 3,4…
- Redirect in HALT to 0 -> halted=0, fetch resumes from 0.
- Wrap: redirect to 30, memory holds NOPs at 30/31 -> if_pc 30, 31, 0.
- Async reset pulse mid-stream (between clock edges) -> if_valid, halted, prog_addr go to 0 immediately without waiting for a clock edge.
